hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage CPU. It produces the stall signal consumed by the PC register's `hazard_i` port and the matching hold, bubble and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It detects load-use hazards and branch-taken flushes, and freezes the pipeline for multi-cycle data-memory accesses. It also maintains a stall-cycle performance counter.

---
 rtl/hazard_pkg.sv | 13 +
 rtl/stall_timer.sv | 25 ++
 rtl/hazard_ctrl.sv | 88 ++++++++
 tb/tb_hazard_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and widths for the pipeline hazard controller
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam int REG_W       = 5;
    localparam int CNT_W       = 4;
    localparam int STALL_CNT_W = 32;

endpackage

// File: rtl/stall_timer.sv
// rtl/stall_timer.sv - loadable down-counter that idles at zero
module stall_timer
    import hazard_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    assign zero = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (!zero) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use/branch/memory-freeze stall controller with stall-cycle counter
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_LAT = 3,
    parameter int REG_W   = hazard_pkg::REG_W
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [REG_W-1:0]       ifid_rs_i,
    input  logic [REG_W-1:0]       ifid_rt_i,
    input  logic                   ifid_use_rt_i,
    input  logic                   idex_memread_i,
    input  logic [REG_W-1:0]       idex_rt_i,
    input  logic                   exmem_memreq_i,
    input  logic                   branch_taken_i,
    output logic                   pc_stall_o,
    output logic                   ifid_stall_o,
    output logic                   ifid_flush_o,
    output logic                   idex_stall_o,
    output logic                   idex_bubble_o,
    output logic                   exmem_stall_o,
    output logic                   memwb_bubble_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    localparam bit MULTI_CYCLE = (MEM_LAT > 1);
    // First freeze cycle is spent in RUN, so the timer only covers the rest.
    localparam int LOAD_VAL = MULTI_CYCLE ? (MEM_LAT - 2) : 0;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic                    cnt_zero;
    logic                    start_wait;
    logic                    freeze;
    logic                    rt_match;
    logic                    lu;
    logic                    flush;
    logic [STALL_CNT_W-1:0]  stall_cnt_q;

    assign start_wait = !rst_i && (state == RUN) && exmem_memreq_i && MULTI_CYCLE;

    stall_timer u_stall_timer (
        .clk   (clk_i),
        .rst   (rst_i),
        .load  (start_wait),
        .value (CNT_W'(LOAD_VAL)),
        .cnt   (cnt),
        .zero  (cnt_zero)
    );

    assign freeze = start_wait || (!rst_i && (state == MEM_WAIT) && !cnt_zero);

    assign rt_match = (idex_rt_i == ifid_rs_i) || (ifid_use_rt_i && (idex_rt_i == ifid_rt_i));
    assign lu       = !rst_i && !freeze && idex_memread_i && (idex_rt_i != '0) && rt_match;
    assign flush    = !rst_i && !freeze && !lu && branch_taken_i;

    assign pc_stall_o     = freeze || lu;
    assign ifid_stall_o   = freeze || lu;
    assign ifid_flush_o   = flush;
    assign idex_stall_o   = freeze;
    assign idex_bubble_o  = lu;
    assign exmem_stall_o  = freeze;
    assign memwb_bubble_o = freeze;
    assign stall_cnt_o    = stall_cnt_q;

    // The request seen on the completion cycle belongs to the finishing access.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:      if (start_wait) state <= MEM_WAIT;
                MEM_WAIT: if (cnt_zero) state <= RUN;
                default:  state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (pc_stall_o) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized and directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam int L = 3;
    localparam logic [6:0] V_FRZ = 7'b1101011;
    localparam logic [6:0] V_LU  = 7'b1100100;
    localparam logic [6:0] V_FL  = 7'b0010000;
    localparam logic [6:0] V_0   = 7'b0000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  ifid_rs = '0, ifid_rt = '0, idex_rt = '0;
    logic        ifid_use_rt = 1'b0, idex_memread = 1'b0, exmem_memreq = 1'b0, branch_taken = 1'b0;
    logic        pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble, exmem_stall, memwb_bubble;
    logic [31:0] stall_cnt;

    bit          lit_en = 1'b0;
    logic [6:0]  lit_vec = '0;
    longint      lit_cnt = -1;
    bit          want_wrap = 1'b0;
    bit          stim_done = 1'b0;

    int          total = 0;
    int          bad = 0;

    hazard_ctrl #(.MEM_LAT(L), .REG_W(5)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ifid_rs_i      (ifid_rs),
        .ifid_rt_i      (ifid_rt),
        .ifid_use_rt_i  (ifid_use_rt),
        .idex_memread_i (idex_memread),
        .idex_rt_i      (idex_rt),
        .exmem_memreq_i (exmem_memreq),
        .branch_taken_i (branch_taken),
        .pc_stall_o     (pc_stall),
        .ifid_stall_o   (ifid_stall),
        .ifid_flush_o   (ifid_flush),
        .idex_stall_o   (idex_stall),
        .idex_bubble_o  (idex_bubble),
        .exmem_stall_o  (exmem_stall),
        .memwb_bubble_o (memwb_bubble),
        .stall_cnt_o    (stall_cnt)
    );

    always #5 clk = ~clk;

    // Model: an access accepted at cycle t completes at t+L-1; cycles before that are frozen.
    int          cyc = 0;
    int          done_cyc = -1;
    bit          cnt_known = 1'b0;
    logic [31:0] exp_cnt = '0;

    always @(negedge clk) begin
        logic [6:0] ev, dv;
        bit in_acc, frz, lu, fl;
        if (want_wrap) exp_cnt = 32'hFFFF_FFFF;
        in_acc = (cyc <= done_cyc);
        frz = in_acc ? (cyc < done_cyc) : (exmem_memreq && (L > 1));
        lu  = !frz && idex_memread && (idex_rt != 0) &&
              ((idex_rt == ifid_rs) || (ifid_use_rt && (idex_rt == ifid_rt)));
        fl  = branch_taken && !frz && !lu;
        if (rst) ev = V_0;
        else if (frz) ev = V_FRZ;
        else if (lu) ev = V_LU;
        else if (fl) ev = V_FL;
        else ev = V_0;
        dv = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble, exmem_stall, memwb_bubble};

        total++;
        if (dv !== ev) begin
            bad++;
            $display("FAIL ctrl cyc=%0d got=%b want=%b", cyc, dv, ev);
        end
        if (cnt_known) begin
            total++;
            if (stall_cnt !== exp_cnt) begin
                bad++;
                $display("FAIL stall_cnt cyc=%0d got=%0h want=%0h", cyc, stall_cnt, exp_cnt);
            end
        end
        if (lit_en) begin
            total++;
            if (dv !== lit_vec || ev !== lit_vec) begin
                bad++;
                $display("FAIL lit_ctrl cyc=%0d dut=%b model=%b want=%b", cyc, dv, ev, lit_vec);
            end
            if (lit_cnt >= 0) begin
                total++;
                if (stall_cnt !== lit_cnt[31:0] || exp_cnt !== lit_cnt[31:0]) begin
                    bad++;
                    $display("FAIL lit_cnt cyc=%0d dut=%0h model=%0h want=%0h",
                             cyc, stall_cnt, exp_cnt, lit_cnt[31:0]);
                end
            end
        end

        if (rst) begin
            done_cyc  = -1;
            exp_cnt   = '0;
            cnt_known = 1'b1;
        end else begin
            if (!in_acc && exmem_memreq && (L > 1)) done_cyc = cyc + L - 1;
            if (ev[6]) exp_cnt = exp_cnt + 1;
        end
        cyc++;
    end

    task automatic drive(input logic r, input logic mr, input logic [4:0] drt, input logic [4:0] drs,
                         input logic [4:0] drr, input logic urt, input logic mq, input logic b,
                         input bit le, input logic [6:0] lv, input longint lc);
        @(posedge clk);
        #1;
        rst = r; idex_memread = mr; idex_rt = drt; ifid_rs = drs; ifid_rt = drr;
        ifid_use_rt = urt; exmem_memreq = mq; branch_taken = b;
        lit_en = le; lit_vec = lv; lit_cnt = lc; want_wrap = 1'b0;
    endtask

    initial begin
        // reset
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, V_0, -1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, V_0, 0);
        // load-use on rs, then bubble clears the load
        drive(0, 1, 5, 5, 0, 0, 0, 0, 1, V_LU, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, V_0, 1);
        // register 0 never hazards
        drive(0, 1, 0, 0, 0, 1, 0, 0, 1, V_0, 1);
        // memory latency 3, request held through completion
        drive(0, 0, 0, 0, 0, 0, 1, 0, 1, V_FRZ, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 1, V_FRZ, 2);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 1, V_0, 3);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, V_0, 3);
        // priority: freeze > load-use (rt path) > flush
        drive(0, 1, 7, 1, 7, 1, 1, 1, 1, V_FRZ, 3);
        drive(0, 1, 7, 1, 7, 1, 1, 1, 1, V_FRZ, 4);
        drive(0, 1, 7, 1, 7, 1, 1, 1, 1, V_LU, 5);
        drive(0, 0, 7, 1, 7, 1, 0, 1, 1, V_FL, 6);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, V_0, 6);
        // back-to-back accesses
        drive(0, 0, 0, 0, 0, 0, 1, 0, 1, V_FRZ, 6);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 1, V_FRZ, 7);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 1, V_0, 8);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 1, V_FRZ, 8);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, V_FRZ, 9);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, V_0, 10);
        // reset in MEM_WAIT aborts the wait
        drive(0, 0, 0, 0, 0, 0, 1, 0, 1, V_FRZ, 10);
        drive(1, 1, 3, 3, 0, 0, 1, 1, 1, V_0, 11);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, V_0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 1, V_FRZ, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, V_FRZ, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, V_0, 2);
        // counter wrap
        @(posedge clk);
        #1;
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        release dut.stall_cnt_q;
        want_wrap = 1'b1;
        idex_memread = 1; idex_rt = 9; ifid_rs = 9; ifid_use_rt = 0; exmem_memreq = 0; branch_taken = 0;
        lit_en = 1; lit_vec = V_LU; lit_cnt = 64'h0000_0000_FFFF_FFFF;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, V_0, 0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 40),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 25),
                  ($urandom_range(0, 99) < 30), 0, V_0, -1);
        end
        @(negedge clk);
        #1;
        stim_done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
